// File: rtl/instr_fetch_mem.sv
// ----------------------------------------------------------------------------
// instr_fetch_mem
//
// Single-ported instruction memory with a one-deep registered fetch response
// and a load port for filling the memory.
//
// Fetch side: a request (req_valid & req_ready) is answered on the next rising
// edge with rsp_valid=1. The response register holds its value until the
// consumer takes it (rsp_ready). A new request may be accepted in the same
// cycle the held response is taken, so back-to-back fetches run at one per
// cycle. A PC outside the implemented depth returns NOP_INSTR with rsp_fault=1.
//
// Load side: every cycle with ld_en=1 writes ld_data to ld_addr if that
// address is implemented. Out-of-range load addresses are dropped silently.
// While ld_en is high, or while the FSM is still in LOAD, fetches are stalled.
//
// flush discards the held response and any request accepted in the same
// cycle. rst returns the FSM to RUN and clears the response. Memory contents
// are never reset.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   fetch request present
//   req_pc     in   fetch word address            [INSTR_ADDRW]
//   req_ready  out  request accepted this cycle (combinational)
//   rsp_valid  out  rsp_instr / rsp_fault valid
//   rsp_ready  in   consumer takes the response
//   rsp_instr  out  fetched instruction           [INSTR_SIZE]
//   rsp_fault  out  fetched PC was out of range
//   flush      in   discard the held response
//   ld_en      in   load-port write this cycle
//   ld_addr    in   load-port word address        [INSTR_ADDRW]
//   ld_data    in   load-port write data          [INSTR_SIZE]
//   loading    out  FSM is in LOAD
// ----------------------------------------------------------------------------
module instr_fetch_mem #(
    parameter int unsigned            INSTR_SIZE  = 32,
    parameter int unsigned            INSTR_ADDRW = 8,
    parameter int unsigned            INSTR_DEPTH = 256,
    parameter logic [INSTR_SIZE-1:0]  NOP_INSTR   = 32'h00000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic [INSTR_ADDRW-1:0] req_pc,
    output logic                   req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [INSTR_SIZE-1:0]  rsp_instr,
    output logic                   rsp_fault,
    input  logic                   flush,
    input  logic                   ld_en,
    input  logic [INSTR_ADDRW-1:0] ld_addr,
    input  logic [INSTR_SIZE-1:0]  ld_data,
    output logic                   loading
);

    // Index width of the implemented array; at least one bit.
    localparam int unsigned IdxW = (INSTR_DEPTH > 1) ? $clog2(INSTR_DEPTH) : 1;

    // Depth as an (INSTR_ADDRW+1)-bit value so that a depth of exactly
    // 2**INSTR_ADDRW is representable and the range compare never wraps.
    localparam logic [INSTR_ADDRW:0] DepthLim = (INSTR_ADDRW + 1)'(INSTR_DEPTH);

    typedef enum logic [0:0] {
        StRun,
        StLoad
    } state_e;

    state_e                  state_q;
    logic                    rsp_valid_q;
    logic                    rsp_fault_q;
    logic [INSTR_SIZE-1:0]   rsp_instr_q;
    logic [INSTR_SIZE-1:0]   mem_q [INSTR_DEPTH];

    logic                    req_in_range;
    logic                    ld_in_range;
    logic                    accept;
    logic [IdxW-1:0]         req_idx;
    logic [IdxW-1:0]         ld_idx;
    logic [INSTR_SIZE-1:0]   rd_word;

    // Full-width range checks: zero-extend the address by one bit.
    assign req_in_range = ({1'b0, req_pc}  < DepthLim);
    assign ld_in_range  = ({1'b0, ld_addr} < DepthLim);

    // Truncated indices are only used when the matching range check passes.
    assign req_idx = req_pc[IdxW-1:0];
    assign ld_idx  = ld_addr[IdxW-1:0];

    assign rd_word = mem_q[req_idx];

    // Accept only in RUN, never on a load cycle, and only if the response
    // register is empty or being emptied this cycle.
    assign req_ready = (state_q == StRun) & ~ld_en & (~rsp_valid_q | rsp_ready);
    assign accept    = req_valid & req_ready;

    // ------------------------------------------------------------------------
    // Memory array: no reset, writes suppressed on reset cycles. A write and a
    // fetch of the same word in one cycle return the old contents.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && ld_en && ld_in_range) begin
            mem_q[ld_idx] <= ld_data;
        end
    end

    // ------------------------------------------------------------------------
    // Load FSM and response register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_instr_q <= NOP_INSTR;
        end else begin
            unique case (state_q)
                StRun:   if (ld_en)  state_q <= StLoad;
                StLoad:  if (!ld_en) state_q <= StRun;
                default: state_q <= StRun;
            endcase

            if (flush) begin
                // Drops the held response and any request accepted this cycle.
                rsp_valid_q <= 1'b0;
                rsp_fault_q <= 1'b0;
                rsp_instr_q <= NOP_INSTR;
            end else if (accept) begin
                rsp_valid_q <= 1'b1;
                rsp_fault_q <= ~req_in_range;
                rsp_instr_q <= req_in_range ? rd_word : NOP_INSTR;
            end else if (rsp_valid_q && rsp_ready) begin
                // Data is left in place; only the valid flag drops.
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_fault = rsp_fault_q;
    assign rsp_instr = rsp_instr_q;
    assign loading   = (state_q == StLoad);

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 SHALL take parameter INSTR_SIZE, default 32, meaning instruction word width in bits.
REQ-002 SHALL take parameter INSTR_ADDRW, default 8, meaning PC/word-address width in bits.
REQ-003 SHALL take parameter INSTR_DEPTH, default 256, meaning implemented words; INSTR_DEPTH <= 2**INSTR_ADDRW.
REQ-004 SHALL take parameter NOP_INSTR, default 32'h00000000, meaning the word returned on fault or flush-fill.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port req_valid, input, 1, meaning a fetch request is present.
REQ-008 SHALL have port req_pc, input, INSTR_ADDRW, meaning the word address of the fetch.
REQ-009 SHALL have port req_ready, output, 1, meaning a request is accepted this cycle.
REQ-010 SHALL have port rsp_valid, output, 1, meaning rsp_instr/rsp_fault are valid.
REQ-011 SHALL have port rsp_ready, input, 1, meaning the consumer takes the response.
REQ-012 SHALL have port rsp_instr, output, INSTR_SIZE, meaning the fetched instruction.
REQ-013 SHALL have port rsp_fault, output, 1, meaning the fetched PC was out of range.
REQ-014 SHALL have port flush, input, 1, meaning discard the held response.
REQ-015 SHALL have port ld_en, input, 1, meaning a load-port write this cycle.
REQ-016 SHALL have port ld_addr, input, INSTR_ADDRW, meaning the load-port word address.
REQ-017 SHALL have port ld_data, input, INSTR_SIZE, meaning the load-port write data.
REQ-018 SHALL have port loading, output, 1, meaning the FSM is in LOAD.

Function
REQ-019 SHALL hold INSTR_DEPTH words of INSTR_SIZE bits, with contents undefined until written and unaffected by rst.
REQ-020 SHALL implement FSM {RUN, LOAD}: RUN->LOAD when ld_en=1; LOAD->RUN on the first cycle ld_en=0; loading=1 iff state=LOAD.
REQ-021 SHALL write ld_data to word ld_addr on every cycle ld_en=1 and ld_addr<INSTR_DEPTH, and SHALL ignore out-of-range ld_addr silently.
REQ-022 SHALL drive req_ready = (state=RUN) & ~ld_en & (~rsp_valid | rsp_ready), combinationally.
REQ-023 SHALL treat a request as accepted on a cycle with req_valid & req_ready, and SHALL present its response on the following edge (1-cycle latency) with rsp_valid=1.
REQ-024 SHALL, for an accepted req_pc >= INSTR_DEPTH, return rsp_instr=NOP_INSTR and rsp_fault=1, otherwise memory[req_pc] and rsp_fault=0.
REQ-025 SHALL hold rsp_instr, rsp_fault and rsp_valid stable while rsp_valid=1 and rsp_ready=0.
REQ-026 SHALL clear rsp_valid on the edge after rsp_valid & rsp_ready unless a new request is accepted in that same cycle, which sustains one response per cycle back-to-back.
REQ-027 SHALL, when flush=1, clear rsp_valid on the next edge, drive rsp_instr=NOP_INSTR and rsp_fault=0, and discard any request accepted in the same cycle.
REQ-028 SHALL give flush priority over ld_en and over request acceptance; ld_en still writes memory during flush.
REQ-029 SHALL not alter a held response when ld_en writes its source address; the response reflects the contents at acceptance time.
REQ-030 SHALL make address comparisons at full INSTR_ADDRW width with no wrap; a PC of 2**INSTR_ADDRW-1 is in range only if INSTR_DEPTH = 2**INSTR_ADDRW.

Reset
REQ-031 SHALL, on rst=1 at a rising edge, set state=RUN, rsp_valid=0, rsp_fault=0 and rsp_instr=NOP_INSTR, and SHALL discard any in-flight or held response.
REQ-032 SHALL have rst override flush, ld_en and requests, and SHALL perform no memory write on a reset cycle.
REQ-033 SHALL allow a request to be accepted on the first cycle after rst deasserts.

Verification
REQ-034 SHALL pass this scenario: ld_en with writes 0->32'h8800000F and 1->32'h12345678, then fetch PC 0 then 1 back-to-back with rsp_ready=1 -> rsp_valid on two consecutive cycles carrying 8800000F then 12345678, with rsp_fault=0.
REQ-035 SHALL pass this scenario: DEPTH=200 and fetch PC 250 -> rsp_instr=NOP_INSTR and rsp_fault=1 one cycle later.
REQ-036 SHALL pass this scenario: response held with rsp_ready=0 for 3 cycles while req_valid=1 -> req_ready=0 and outputs stable, then rsp_ready=1 -> the next request is accepted that cycle.
REQ-037 SHALL pass this scenario: flush asserted together with an accepted request -> rsp_valid=0 next cycle and no response appears for that request.
REQ-038 SHALL pass this scenario: ld_en=1 while req_valid=1 -> req_ready=0 and loading=1 on the following cycle; ld_en drops -> loading=0 and req_ready=1 one cycle later.
REQ-039 SHALL pass this scenario: rst asserted while a response is held -> rsp_valid=0 and rsp_instr=NOP_INSTR after the edge, and memory contents are preserved when PC 0 is refetched.
